// File: rtl/hms_time_counter.sv
// rtl/hms_time_counter.sv - HH:MM:SS BCD time-of-day counter with run/stop, adjust and seconds clear
module hms_time_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    input  logic       sec_clr,
    input  logic       adj_min,
    input  logic       adj_hr,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic       day_carry
);

    // Wrap flags: a field at (or beyond) its top value goes to 0 on increment,
    // which also pulls any out-of-range digit back into range.
    logic       s1_wrap;
    logic       s10_wrap;
    logic       m1_wrap;
    logic       m10_wrap;
    logic       hr_wrap;
    logic [3:0] sec_ones_nxt;
    logic [2:0] sec_tens_nxt;
    logic [3:0] min_ones_nxt;
    logic [2:0] min_tens_nxt;
    logic [3:0] hr_ones_nxt;
    logic [1:0] hr_tens_nxt;

    // Per-digit incremented values and the wrap conditions that drive the ripple.
    always_comb begin
        s1_wrap  = (sec_ones >= 4'd9);
        s10_wrap = (sec_tens >= 3'd5);
        m1_wrap  = (min_ones >= 4'd9);
        m10_wrap = (min_tens >= 3'd5);
        hr_wrap  = (hr_tens > 2'd2) || ((hr_tens == 2'd2) && (hr_ones >= 4'd3));

        sec_ones_nxt = s1_wrap  ? 4'd0 : sec_ones + 4'd1;
        sec_tens_nxt = s10_wrap ? 3'd0 : sec_tens + 3'd1;
        min_ones_nxt = m1_wrap  ? 4'd0 : min_ones + 4'd1;
        min_tens_nxt = m10_wrap ? 3'd0 : min_tens + 3'd1;

        if (hr_wrap) begin
            hr_ones_nxt = 4'd0;
            hr_tens_nxt = 2'd0;
        end else if (hr_ones >= 4'd9) begin
            hr_ones_nxt = 4'd0;
            hr_tens_nxt = hr_tens + 2'd1;
        end else begin
            hr_ones_nxt = hr_ones + 4'd1;
            hr_tens_nxt = hr_tens;
        end
    end

    // Apply exactly one action per edge: clear > hour adjust > minute adjust > counted tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_ones  <= 4'd0;
            sec_tens  <= 3'd0;
            min_ones  <= 4'd0;
            min_tens  <= 3'd0;
            hr_ones   <= 4'd0;
            hr_tens   <= 2'd0;
            day_carry <= 1'b0;
        end else begin
            day_carry <= 1'b0;
            if (sec_clr) begin
                sec_ones <= 4'd0;
                sec_tens <= 3'd0;
            end else if (adj_hr) begin
                hr_ones <= hr_ones_nxt;
                hr_tens <= hr_tens_nxt;
            end else if (adj_min) begin
                min_ones <= min_ones_nxt;
                if (m1_wrap) begin
                    min_tens <= min_tens_nxt;
                end
            end else if (tick && run) begin
                sec_ones <= sec_ones_nxt;
                if (s1_wrap) begin
                    sec_tens <= sec_tens_nxt;
                    if (s10_wrap) begin
                        min_ones <= min_ones_nxt;
                        if (m1_wrap) begin
                            min_tens <= min_tens_nxt;
                            if (m10_wrap) begin
                                hr_ones   <= hr_ones_nxt;
                                hr_tens   <= hr_tens_nxt;
                                day_carry <= hr_wrap;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/hms_time_counter.md
Name: hms_time_counter

Overview:
- Time-of-day counter for the digital clock module, directly downstream of the 1 Hz tick source.
- Holds HH:MM:SS as six BCD-style digit fields: units digits mod 10, tens-of-seconds and tens-of-minutes mod 6, hours mod 24.
- Advances once per qualified tick.
- Provides run/stop, field adjust and seconds clear for the set buttons.
- Digit outputs feed the display decoder/scanner directly.

Parameters:
None.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-low (0 = reset)
tick  input  1  1-cycle pulse, one per second, synchronous to clk
run  input  1  1 = count on tick; 0 = hold (adjust still allowed)
sec_clr  input  1  1-cycle pulse: seconds fields to 00
adj_min  input  1  1-cycle pulse: minutes +1
adj_hr  input  1  1-cycle pulse: hours +1
sec_ones  output  4  seconds units, 0-9
sec_tens  output  3  seconds tens, 0-5
min_ones  output  4  minutes units, 0-9
min_tens  output  3  minutes tens, 0-5
hr_ones  output  4  hours units, 0-9 (0-3 when hr_tens=2)
hr_tens  output  2  hours tens, 0-2
day_carry  output  1  1-cycle pulse on 23:59:59 -> 00:00:00 rollover

Behaviour:
- Clock and reset: one clock domain; clk rising edge.
- rst is asynchronous and active-low.
- While rst=0, all outputs are 0 immediately, including day_carry. Count shows 00:00:00.
- Reset asserted mid-count discards all state. Counting resumes from 00:00:00 on the first tick after rst returns to 1.
- All outputs are registered. No combinational path from inputs to outputs.
- Per-edge action priority (only the highest-priority active action is applied in a cycle):
  1. sec_clr
  2. adj_hr
  3. adj_min
  4. tick & run
- sec_clr: sec_ones=0, sec_tens=0. Minutes and hours unchanged. Any tick in the same cycle is dropped.
- adj_hr: hours +1 mod 24, no carry out; 23 -> 00. Minutes and seconds unchanged. day_carry stays 0.
- adj_min: minutes +1 mod 60, no carry into hours; 59 -> 00. Seconds unchanged.
- A tick coincident with any adjust or clear is dropped, not deferred.
- tick & run, ripple increment within the same edge (1-cycle latency: the new value is visible the cycle after the tick is sampled):
  - sec_ones 9 -> 0 carries to sec_tens.
  - sec_tens 5 -> 0 carries to min_ones.
  - min_ones 9 -> 0 carries to min_tens.
  - min_tens 5 -> 0 carries to hours.
  - Hours: ones 9 -> 0 with tens+1. At hr_tens=2, hr_ones=3 (23), the carry wraps to 00.
- day_carry is registered high for exactly the one cycle in which the outputs first read 00:00:00 after a tick-driven rollover. Otherwise 0.
- run=0: tick is ignored. Fields hold. Adjust and clear still act.
- Illegal-state recovery: a digit outside its range (not reachable in normal operation) returns to 0 on the next increment of that field.
- Fields that are not incremented in a cycle hold their value.
- Consecutive ticks on back-to-back cycles are each counted.

Test Plan:
- Reset and count: rst=0 -> all outputs 0. Release rst, run=1, 10 ticks -> 00:00:10 (sec_tens=1, sec_ones=0).
- Minute rollover: preload via ticks to 00:00:59, tick -> 00:01:00. Then, via adj_min, reach 00:59:59; tick -> 01:00:00, day_carry=0.
- Day rollover: adjust to 23:59:59, tick -> 00:00:00, day_carry=1 for exactly one cycle, then 0.
- Adjust wrap: at 23:45:30, adj_hr -> 00:45:30. Then 14x adj_min -> 00:59:30, one more adj_min -> 00:00:30 (no hour carry), day_carry never 1.
- Priority: at 00:00:42, assert sec_clr, adj_min and tick in the same cycle -> 00:00:00, minutes unchanged. Then adj_min and tick together -> 00:01:00.
- Hold and async reset: run=0, 5 ticks -> value unchanged. Then, mid-sequence between clk edges, assert rst=0 -> outputs 0 before the next clk edge.
